rpc_pixel_server: RTL and testbench
===================================

RPC_PIXEL_SERVER -- requirements
Module: rpc_pixel_server

Interface
- REQ-001 Parameter XBITS, default 4, log2 of frame width in pixels.
- REQ-002 Parameter YBITS, default 4, log2 of frame height in pixels.
- REQ-003 Parameter SERVER_ID, default 32'h0000_0019, base value returned by get_id.
- REQ-004 clk  input  1  single clock; all state changes on its rising edge.
- REQ-005 reset  input  1  asynchronous, active-high reset.
- REQ-006 start_req / start_ack  input / output  1 / 1  start-call handshake.
- REQ-007 get_id_req / get_id_ack  input / output  1 / 1  get_id-call handshake.
- REQ-008 get_id_return  output  32  get_id result, valid while get_id_ack is high.
- REQ-009 setget_pixel_req / setget_pixel_ack  input / output  1 / 1  pixel-call handshake.
- REQ-010 setget_pixel_x, setget_pixel_y  input  32 each  pixel coordinates, signed.
- REQ-011 setget_pixel_readf  input  1  1 = read, 0 = write.
- REQ-012 setget_pixel_wdata  input  8  write data.
- REQ-013 setget_pixel_return  output  8  read result, valid while setget_pixel_ack is high.

Function
- REQ-014 Every call uses a four-phase handshake: req rises, server raises ack, client drops req, server drops ack; args are sampled on the cycle the call is accepted and must stay stable until ack rises.
- REQ-015 The FSM has states IDLE, EXEC, ACK and WAITLOW, and serves one call at a time.
- REQ-016 In IDLE, one pending req is accepted per cycle with priority start > get_id > setget_pixel; unaccepted reqs remain pending.
- REQ-017 Before the first start call completes, get_id and setget_pixel reqs are not accepted and wait with ack low.
- REQ-018 start: IDLE->ACK in one cycle; sets the sticky started flag; a repeated start is acknowledged with no other effect.
- REQ-019 get_id: IDLE->ACK in one cycle; return = SERVER_ID + call count; call count is a 32-bit counter that increments at ack and wraps modulo 2^32.
- REQ-020 setget_pixel: IDLE->EXEC->ACK, so ack is high on the second rising edge after acceptance.
- REQ-021 In EXEC, a write stores wdata into frame memory; a read registers the stored byte into return.
- REQ-022 Frame memory is 2^(XBITS+YBITS) bytes, addressed y*2^XBITS + x.
- REQ-023 Out-of-range coordinates (x<0, x>=2^XBITS, y<0 or y>=2^YBITS): writes are dropped; reads return 8'h00; the call is still acknowledged.
- REQ-024 ACK: the ack for the served call is high; the FSM stays in ACK while that req is high and moves to WAITLOW when it falls.
- REQ-025 WAITLOW: ack is low; next cycle the FSM returns to IDLE, giving a minimum of one idle cycle between calls.
- REQ-026 At most one ack output is high in any cycle.
- REQ-027 Return outputs hold their last value outside ack.
- REQ-028 A req that falls before ack (protocol violation) is still completed; the FSM then passes ACK->WAITLOW on the next edge.

Reset
- REQ-029 Reset forces: state IDLE; all acks 0; get_id_return 0; setget_pixel_return 0; call count 0; started 0.
- REQ-030 Frame memory contents are not reset.
- REQ-031 Reset asserted mid-call aborts the call; a write in EXEC at reset assertion is not guaranteed to land.

Configuration
- REQ-032 Macro RPC_PIXEL_SERVER_ERRFLAG_EN, when defined, adds output oob_err (1 bit, reset 0) that sets on any out-of-range setget_pixel call and clears only on reset; when undefined, the port and its logic are absent and all other behaviour is identical.

Verification
- REQ-033 Reset release, then setget_pixel_req=1 with no prior start -> setget_pixel_ack stays 0 for 20 cycles; then start_req=1 -> start_ack=1 one cycle later, followed by the pending pixel call being acknowledged.
- REQ-034 After start: write x=3, y=5, wdata=8'hA7, then read x=3, y=5 -> return=8'hA7, with ack two edges after acceptance.
- REQ-035 Write x=-1, y=0, wdata=8'h55, then read x=16, y=0 -> both acked, read returns 8'h00, oob_err=1 when the macro is defined.
- REQ-036 Three get_id calls -> returns 32'h19, 32'h1A, 32'h1B.
- REQ-037 start_req, get_id_req and setget_pixel_req raised in the same cycle -> acks occur in order start, get_id, pixel, never overlapping, each separated by at least one idle cycle.
- REQ-038 Reset asserted while in ACK for get_id -> get_id_ack drops immediately, and the next get_id returns 32'h19 only after a new start call.

Source files
------------

// File: rtl/rpc_pixel_server_if.sv
// rpc_pixel_server_if
// Call/return bus for the pixel RPC server. Every call uses a four-phase
// req/ack handshake; arguments travel with the req, results with the ack.
//   slave  modport : the server (samples reqs and args, drives acks and results)
//   master modport : the client (drives reqs and args, samples acks and results)
interface rpc_pixel_server_if;
    logic        start_req;
    logic        start_ack;
    logic        get_id_req;
    logic        get_id_ack;
    logic [31:0] get_id_return;
    logic        setget_pixel_req;
    logic        setget_pixel_ack;
    logic [31:0] setget_pixel_x;
    logic [31:0] setget_pixel_y;
    logic        setget_pixel_readf;
    logic [7:0]  setget_pixel_wdata;
    logic [7:0]  setget_pixel_return;

    modport slave (
        input  start_req, get_id_req, setget_pixel_req,
        input  setget_pixel_x, setget_pixel_y, setget_pixel_readf, setget_pixel_wdata,
        output start_ack, get_id_ack, get_id_return,
        output setget_pixel_ack, setget_pixel_return
    );

    modport master (
        output start_req, get_id_req, setget_pixel_req,
        output setget_pixel_x, setget_pixel_y, setget_pixel_readf, setget_pixel_wdata,
        input  start_ack, get_id_ack, get_id_return,
        input  setget_pixel_ack, setget_pixel_return
    );
endinterface

// File: rtl/rpc_pixel_server.sv
// rpc_pixel_server
// Serves three RPC calls over four-phase handshakes, one call at a time:
//   start        - enables the other two calls (sticky until reset)
//   get_id       - returns SERVER_ID + number of get_id calls already served
//   setget_pixel - reads or writes one byte of a 2^XBITS x 2^YBITS frame
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high
//   bus     : rpc_pixel_server_if.slave, all req/ack/argument/result signals
//   oob_err : (only with RPC_PIXEL_SERVER_ERRFLAG_EN defined) sticky flag set
//             by any out-of-range setget_pixel call, cleared only by reset
// Optional feature macro: RPC_PIXEL_SERVER_ERRFLAG_EN
module rpc_pixel_server #(
    parameter int          XBITS     = 4,
    parameter int          YBITS     = 4,
    parameter logic [31:0] SERVER_ID = 32'h0000_0019
) (
    input  logic clk,
    input  logic reset,
`ifdef RPC_PIXEL_SERVER_ERRFLAG_EN
    output logic oob_err,
`endif
    rpc_pixel_server_if.slave bus
);

    localparam int ABITS = XBITS + YBITS;
    localparam int DEPTH = 1 << ABITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_ACK     = 2'd2,
        ST_WAITLOW = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CALL_NONE  = 2'd0,
        CALL_START = 2'd1,
        CALL_ID    = 2'd2,
        CALL_PIXEL = 2'd3
    } call_t;

    // A signed coordinate is in range when every bit at or above 'bits' is
    // zero: that rejects both negatives and values >= 2^bits in one test.
    function automatic logic coord_in_range(input logic [31:0] c, input int bits);
        return (c >> bits) == 32'd0;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    call_t              call_r;
    call_t              call_next_s;
    logic               started_r;
    logic [31:0]        count_r;
    logic               start_ack_r;
    logic               get_id_ack_r;
    logic               pixel_ack_r;
    logic [31:0]        get_id_return_r;
    logic [7:0]         pixel_return_r;
    logic [ABITS-1:0]   addr_r;
    logic               in_range_r;
    logic               readf_r;
    logic [7:0]         wdata_r;
    logic               accept_start_s;
    logic               accept_id_s;
    logic               accept_pixel_s;
    logic               served_req_s;
    logic               arg_in_range_s;
    logic [ABITS-1:0]   arg_addr_s;
    logic [7:0]         mem_r [DEPTH];

    assign arg_in_range_s = coord_in_range(bus.setget_pixel_x, XBITS) &&
                            coord_in_range(bus.setget_pixel_y, YBITS);
    assign arg_addr_s     = {bus.setget_pixel_y[YBITS-1:0], bus.setget_pixel_x[XBITS-1:0]};

    // Next-state logic: priority accept in IDLE, hold in ACK while req is high.
    always_comb begin
        state_next_s   = state_r;
        call_next_s    = call_r;
        accept_start_s = 1'b0;
        accept_id_s    = 1'b0;
        accept_pixel_s = 1'b0;
        served_req_s   = 1'b0;

        case (call_r)
            CALL_START: served_req_s = bus.start_req;
            CALL_ID:    served_req_s = bus.get_id_req;
            CALL_PIXEL: served_req_s = bus.setget_pixel_req;
            default:    served_req_s = 1'b0;
        endcase

        case (state_r)
            ST_IDLE: begin
                if (bus.start_req) begin
                    accept_start_s = 1'b1;
                    call_next_s    = CALL_START;
                    state_next_s   = ST_ACK;
                end else if (started_r && bus.get_id_req) begin
                    accept_id_s  = 1'b1;
                    call_next_s  = CALL_ID;
                    state_next_s = ST_ACK;
                end else if (started_r && bus.setget_pixel_req) begin
                    accept_pixel_s = 1'b1;
                    call_next_s    = CALL_PIXEL;
                    state_next_s   = ST_EXEC;
                end else begin
                    call_next_s  = CALL_NONE;
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_ACK;
            ST_ACK: begin
                // A req dropped early (before ack) simply falls through here.
                if (served_req_s) begin
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_WAITLOW;
                end
            end
            ST_WAITLOW: begin
                state_next_s = ST_IDLE;
                call_next_s  = CALL_NONE;
            end
            default: begin
                state_next_s = ST_IDLE;
                call_next_s  = CALL_NONE;
            end
        endcase
    end

    // State, acks, results and latched call arguments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            call_r          <= CALL_NONE;
            started_r       <= 1'b0;
            count_r         <= 32'd0;
            start_ack_r     <= 1'b0;
            get_id_ack_r    <= 1'b0;
            pixel_ack_r     <= 1'b0;
            get_id_return_r <= 32'd0;
            pixel_return_r  <= 8'h00;
            addr_r          <= '0;
            in_range_r      <= 1'b0;
            readf_r         <= 1'b0;
            wdata_r         <= 8'h00;
        end else begin
            state_r      <= state_next_s;
            call_r       <= call_next_s;
            // Acks follow the next state so exactly one is high, only in ACK.
            start_ack_r  <= (state_next_s == ST_ACK) && (call_next_s == CALL_START);
            get_id_ack_r <= (state_next_s == ST_ACK) && (call_next_s == CALL_ID);
            pixel_ack_r  <= (state_next_s == ST_ACK) && (call_next_s == CALL_PIXEL);
            if (accept_start_s) begin
                started_r <= 1'b1;
            end
            if (accept_id_s) begin
                get_id_return_r <= SERVER_ID + count_r;
                count_r         <= count_r + 32'd1;
            end
            if (accept_pixel_s) begin
                addr_r     <= arg_addr_s;
                in_range_r <= arg_in_range_s;
                readf_r    <= bus.setget_pixel_readf;
                wdata_r    <= bus.setget_pixel_wdata;
            end
            if ((state_r == ST_EXEC) && readf_r) begin
                pixel_return_r <= in_range_r ? mem_r[addr_r] : 8'h00;
            end
        end
    end

    // Frame memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((state_r == ST_EXEC) && !readf_r && in_range_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

`ifdef RPC_PIXEL_SERVER_ERRFLAG_EN
    logic oob_err_r;

    // Sticky out-of-range flag, set while executing a bad pixel call.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_err_r <= 1'b0;
        end else if ((state_r == ST_EXEC) && !in_range_r) begin
            oob_err_r <= 1'b1;
        end
    end

    assign oob_err = oob_err_r;
`endif

    assign bus.start_ack           = start_ack_r;
    assign bus.get_id_ack          = get_id_ack_r;
    assign bus.get_id_return       = get_id_return_r;
    assign bus.setget_pixel_ack    = pixel_ack_r;
    assign bus.setget_pixel_return = pixel_return_r;

endmodule

// File: tb/tb_rpc_pixel_server.sv
// tb_rpc_pixel_server
// Directed, table-driven bench for rpc_pixel_server: a table of pixel calls
// with hand-computed results, plus hand-written sequences for the start gate,
// get_id counting, simultaneous requests and reset during a call.
module tb_rpc_pixel_server;

    logic clk;
    logic reset;
`ifdef RPC_PIXEL_SERVER_ERRFLAG_EN
    logic oob_err;
`endif

    rpc_pixel_server_if bus_if ();

    rpc_pixel_server dut (
        .clk     (clk),
        .reset   (reset),
`ifdef RPC_PIXEL_SERVER_ERRFLAG_EN
        .oob_err (oob_err),
`endif
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        readf;
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  wdata;
        logic [7:0]  exp_ret;
        logic        oob;
    } vec_t;

    vec_t        vecs [13];
    int          n_total;
    int          n_pass;
    logic [31:0] cap_id;
    logic [7:0]  cap_pix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input int which);
        case (which)
            0:       return bus_if.start_ack;
            1:       return bus_if.get_id_ack;
            default: return bus_if.setget_pixel_ack;
        endcase
    endfunction

    task automatic set_req(input int which, input logic v);
        case (which)
            0:       bus_if.start_req = v;
            1:       bus_if.get_id_req = v;
            default: bus_if.setget_pixel_req = v;
        endcase
    endtask

    // Counts falling edges until the chosen ack is seen; captures results.
    task automatic wait_ack(input int which, input string name, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ack_of(which)) begin
                got     = 1'b1;
                cap_id  = bus_if.get_id_return;
                cap_pix = bus_if.setget_pixel_return;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s_timeout: ack never rose, expected ack within 50 cycles", name);
        end
    endtask

    // Full call: raise req, wait ack, drop req, check ack falls, let FSM reach IDLE.
    task automatic do_call(input int which, input string name, output int lat);
        set_req(which, 1'b1);
        wait_ack(which, name, lat);
        set_req(which, 1'b0);
        @(negedge clk);
        chk({name, "_ack_fall"}, {31'd0, ack_of(which)}, 32'd0);
        @(negedge clk);
    endtask

    task automatic set_pix(input logic readf, input logic [31:0] x, input logic [31:0] y,
                           input logic [7:0] wdata);
        bus_if.setget_pixel_readf = readf;
        bus_if.setget_pixel_x     = x;
        bus_if.setget_pixel_y     = y;
        bus_if.setget_pixel_wdata = wdata;
    endtask

    initial begin
        int   lat;
        bit   seen;
        logic exp_oob;
        n_total = 0;
        n_pass  = 0;
        exp_oob = 1'b0;

        //            readf  x             y             wdata  exp_ret oob
        vecs[0]  = '{1'b0, 32'd3,        32'd5,        8'hA7, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 32'd3,        32'd5,        8'h00, 8'hA7, 1'b0};
        vecs[2]  = '{1'b0, 32'd15,       32'd0,        8'h11, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'd0,       8'h55, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 32'd16,       32'd0,        8'h00, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 32'd15,       32'd0,        8'h00, 8'h11, 1'b0};
        vecs[6]  = '{1'b0, 32'd2,        32'd0,        8'h22, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 32'd2,        32'd16,       8'h99, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 32'd2,        32'd0,        8'h00, 8'h22, 1'b0};
        vecs[9]  = '{1'b1, 32'd3,        32'hFFFF_FFFF, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 32'd0,        32'd0,        8'h00, 8'h5A, 1'b0};
        vecs[11] = '{1'b0, 32'd15,       32'd15,       8'h3C, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 32'd15,       32'd15,       8'h00, 8'h3C, 1'b0};

        bus_if.start_req        = 1'b0;
        bus_if.get_id_req       = 1'b0;
        bus_if.setget_pixel_req = 1'b0;
        set_pix(1'b0, 32'd0, 32'd0, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_start_ack", {31'd0, bus_if.start_ack}, 32'd0);
        chk("rst_get_id_ack", {31'd0, bus_if.get_id_ack}, 32'd0);
        chk("rst_pixel_ack", {31'd0, bus_if.setget_pixel_ack}, 32'd0);
        chk("rst_get_id_return", bus_if.get_id_return, 32'd0);
        chk("rst_pixel_return", {24'd0, bus_if.setget_pixel_return}, 32'd0);
`ifdef RPC_PIXEL_SERVER_ERRFLAG_EN
        chk("rst_oob_err", {31'd0, oob_err}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Pixel call before any start must wait with ack low.
        set_pix(1'b0, 32'd0, 32'd0, 8'h5A);
        bus_if.setget_pixel_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.setget_pixel_ack) seen = 1'b1;
        end
        chk("no_ack_before_start", {31'd0, seen}, 32'd0);
        bus_if.start_req = 1'b1;
        @(negedge clk);
        chk("start_ack_latency", {31'd0, bus_if.start_ack}, 32'd1);
        bus_if.start_req = 1'b0;
        // WAITLOW, IDLE (accept), EXEC, then ACK
        wait_ack(2, "pending_pixel", lat);
        chk("pending_pixel_latency", lat, 32'd4);
        bus_if.setget_pixel_req = 1'b0;
        repeat (2) @(negedge clk);

        // Table of pixel calls
        foreach (vecs[i]) begin
            set_pix(vecs[i].readf, vecs[i].x, vecs[i].y, vecs[i].wdata);
            do_call(2, "pixel", lat);
            chk($sformatf("pixel%0d_latency", i), lat, 32'd2);
            if (vecs[i].readf) begin
                chk($sformatf("pixel%0d_return", i), {24'd0, cap_pix}, {24'd0, vecs[i].exp_ret});
            end
            exp_oob = exp_oob | vecs[i].oob;
`ifdef RPC_PIXEL_SERVER_ERRFLAG_EN
            chk($sformatf("pixel%0d_oob_err", i), {31'd0, oob_err}, {31'd0, exp_oob});
`endif
        end

        // Three get_id calls
        for (int k = 0; k < 3; k++) begin
            do_call(1, "get_id", lat);
            chk($sformatf("get_id%0d_latency", k), lat, 32'd1);
            chk($sformatf("get_id%0d_return", k), cap_id, 32'h19 + k);
        end

        // Results hold outside ack
        chk("hold_get_id_return", bus_if.get_id_return, 32'h1B);
        chk("hold_pixel_return", {24'd0, bus_if.setget_pixel_return}, 32'h3C);

        // All three reqs at once: ordered, never overlapping, spaced apart.
        begin
            int   order [3];
            int   n_acks;
            int   low_run;
            int   min_gap;
            bit   overlap;
            logic [2:0] prev;
            logic [2:0] cur;
            logic [31:0] id_at_ack;
            logic [7:0]  pix_at_ack;
            n_acks = 0; low_run = 0; min_gap = 99; overlap = 1'b0; prev = 3'b000;
            id_at_ack = 32'd0; pix_at_ack = 8'h00;
            set_pix(1'b1, 32'd3, 32'd5, 8'h00);
            bus_if.start_req = 1'b1;
            bus_if.get_id_req = 1'b1;
            bus_if.setget_pixel_req = 1'b1;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                cur = {bus_if.setget_pixel_ack, bus_if.get_id_ack, bus_if.start_ack};
                if ((cur[0] + cur[1] + cur[2]) > 1) overlap = 1'b1;
                for (int b = 0; b < 3; b++) begin
                    if (cur[b] && !prev[b]) begin
                        if (n_acks > 0 && low_run < min_gap) min_gap = low_run;
                        if (n_acks < 3) order[n_acks] = b;
                        n_acks++;
                        if (b == 1) id_at_ack = bus_if.get_id_return;
                        if (b == 2) pix_at_ack = bus_if.setget_pixel_return;
                    end
                end
                if (cur == 3'b000) low_run++; else low_run = 0;
                if (cur[0]) bus_if.start_req = 1'b0;
                if (cur[1]) bus_if.get_id_req = 1'b0;
                if (cur[2]) bus_if.setget_pixel_req = 1'b0;
                prev = cur;
            end
            chk("multi_ack_count", n_acks, 32'd3);
            chk("multi_order0", order[0], 32'd0);
            chk("multi_order1", order[1], 32'd1);
            chk("multi_order2", order[2], 32'd2);
            chk("multi_overlap", {31'd0, overlap}, 32'd0);
            // WAITLOW and the accepting IDLE cycle both keep every ack low.
            chk("multi_min_gap_ge2", {31'd0, (min_gap >= 2)}, 32'd1);
            chk("multi_get_id_return", id_at_ack, 32'h1C);
            chk("multi_pixel_return", {24'd0, pix_at_ack}, 32'hA7);
        end

        // Reset while get_id is in ACK
        bus_if.get_id_req = 1'b1;
        wait_ack(1, "pre_reset_get_id", lat);
        chk("pre_reset_get_id_return", cap_id, 32'h1D);
        reset = 1'b1;
        #1;
        chk("reset_drops_ack", {31'd0, bus_if.get_id_ack}, 32'd0);
        chk("reset_clears_return", bus_if.get_id_return, 32'd0);
        bus_if.get_id_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_if.get_id_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.get_id_ack) seen = 1'b1;
        end
        chk("get_id_blocked_after_reset", {31'd0, seen}, 32'd0);
        do_call(0, "restart", lat);
        chk("restart_latency", lat, 32'd1);
        wait_ack(1, "post_reset_get_id", lat);
        chk("post_reset_get_id_return", cap_id, 32'h19);
        bus_if.get_id_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
